sub_bytes_pipe: RTL and testbench

Parametrised, handshaked AES SubBytes/InvSubBytes engine for the cipher round datapath. It substitutes a 128-bit state using LANES S-box lanes per cycle. Lower LANES values trade area for latency by time-multiplexing the lanes over the 16 bytes. The block sits between the round-key add stage and ShiftRows, with valid/ready flow control on both sides.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox_lane.sv | 44 ++++
 rtl/sub_bytes_pipe.sv | 124 ++++++++++++
 tb/tb_sub_bytes_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg : shared AES byte-substitution tables and types | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Element 0 is the most significant byte, matching the state byte order.
  typedef logic [0:15][AES_BYTE_W-1:0]  block_t;
  typedef logic [0:255][AES_BYTE_W-1:0] sbox_t;

  localparam sbox_t SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // The inverse table is derived from the forward one at elaboration so the two can never disagree.
  function automatic sbox_t invert_sbox(input sbox_t fwd);
    sbox_t inv;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      inv[fwd[i]] = 8'(i);
    end
    return inv;
  endfunction

  localparam sbox_t INV_SBOX = invert_sbox(SBOX);

endpackage

`default_nettype wire

// File: rtl/aes_sbox_lane.sv
// ---------------------------------------------------------------------------
// aes_sbox_lane : one-byte S-box / inverse S-box lookup, optional output reg | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1,
  parameter bit PIPE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AES_BYTE_W-1:0] in_byte_i,
  input  logic                  mode_i,
  output logic [AES_BYTE_W-1:0] out_byte_o
);

  logic [AES_BYTE_W-1:0] w_sub;

  if (INV_EN) begin : g_inv
    assign w_sub = (mode_i == MODE_INV) ? INV_SBOX[in_byte_i] : SBOX[in_byte_i];
  end else begin : g_fwd
    logic w_unused_mode;
    assign w_unused_mode = mode_i;
    assign w_sub         = SBOX[in_byte_i];
  end

  if (PIPE) begin : g_pipe
    logic [AES_BYTE_W-1:0] out_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_q <= '0;
      else      out_q <= w_sub;
    end
    assign out_byte_o = out_q;
  end else begin : g_comb
    logic w_unused_ctl;
    assign w_unused_ctl = clk ^ rst;
    assign out_byte_o   = w_sub;
  end

endmodule

`default_nettype wire

// File: rtl/sub_bytes_pipe.sv
// ---------------------------------------------------------------------------
// sub_bytes_pipe : handshaked AES SubBytes/InvSubBytes over LANES time-shared lanes | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter bit INV_EN = 1'b1,
  parameter bit PIPE   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_mode
);

  localparam int            N         = 16 / LANES;
  localparam int            CW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_pipe: LANES must be one of 1, 2, 4, 8, 16");
  end

  state_e                          state_q, state_d;
  block_t                          src_q, res_q, res_d;
  logic                            mode_q;
  logic [CW-1:0]                   beat_q, p_beat_q;
  logic                            iss_done_q, p_vld_q;
  logic                            w_accept, w_issue_en, w_wr_en;
  logic [CW-1:0]                   w_wr_beat;
  logic [3:0]                      w_rd_base, w_wr_base;
  logic [LANES-1:0][AES_BYTE_W-1:0] w_lane_in, w_lane_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_BUSY;
      ST_BUSY: if (w_wr_en && (w_wr_beat == LAST_BEAT)) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = in_valid ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid  = (state_q == ST_DONE);
    w_issue_en = (state_q == ST_BUSY) && !iss_done_q;
  end

  assign w_accept  = in_valid && in_ready;
  // With PIPE the write trails the issue by the lane register, so it follows a delayed beat index.
  assign w_wr_en   = PIPE ? p_vld_q : w_issue_en;
  assign w_wr_beat = PIPE ? p_beat_q : beat_q;
  assign w_rd_base = 4'(beat_q * LANES);
  assign w_wr_base = 4'(w_wr_beat * LANES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q      <= '0;
      res_q      <= '0;
      mode_q     <= MODE_FWD;
      beat_q     <= '0;
      iss_done_q <= 1'b0;
      p_vld_q    <= 1'b0;
      p_beat_q   <= '0;
    end else begin
      res_q    <= res_d;
      p_vld_q  <= w_issue_en;
      p_beat_q <= beat_q;
      if (w_accept) begin
        src_q      <= in_data;
        mode_q     <= INV_EN ? in_mode : MODE_FWD;
        beat_q     <= '0;
        iss_done_q <= 1'b0;
      end else if (w_issue_en) begin
        if (beat_q == LAST_BEAT) iss_done_q <= 1'b1;
        else                     beat_q     <= beat_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_lane_in[k] = src_q[w_rd_base + 4'(k)];
    aes_sbox_lane #(
      .INV_EN (INV_EN),
      .PIPE   (PIPE)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .in_byte_i  (w_lane_in[k]),
      .mode_i     (mode_q),
      .out_byte_o (w_lane_out[k])
    );
  end

  always_comb begin
    res_d = res_q;
    if (w_wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        res_d[w_wr_base + 4'(k)] = w_lane_out[k];
      end
    end
  end

  assign out_data = res_q;
  assign out_mode = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_pipe.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_pipe : self-checking bench, GF(2^8)-derived S-box reference | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sub_bytes_pipe;

  localparam int A_LAT = 9;  // LANES=2 (N=8), PIPE=1
  localparam int B_LAT = 1;  // LANES=16 (N=1), PIPE=0

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [127:0] a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [127:0] b_in_data, b_out_data;

  sub_bytes_pipe #(.LANES(2), .INV_EN(1'b1), .PIPE(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode)
  );

  sub_bytes_pipe #(.LANES(16), .INV_EN(1'b0), .PIPE(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference S-box built from field arithmetic: multiplicative inverse then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m, input bit inv_en);
    logic [127:0] r;
    logic [7:0]   x;
    for (int j = 0; j < 16; j++) begin
      x = d[127 - 8*j -: 8];
      r[127 - 8*j -: 8] = (m && inv_en) ? isb[x] : sb[x];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present one block to an idle DUT, measure latency from the accept edge, then consume it.
  task automatic run_block(input bit sel, input logic [127:0] d, input logic m,
                           output logic [127:0] r, output logic rm, output int lat);
    if (sel) begin b_in_valid = 1'b1; b_in_data = d; b_in_mode = m; end
    else     begin a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; end
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    lat = 0;
    while (!(sel ? b_out_valid : a_out_valid) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = sel ? b_out_data : a_out_data;
    rm = sel ? b_out_mode : a_out_mode;
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [127:0] din;
    logic         mode;
    logic [127:0] dexp;
    logic         mexp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r, d1, d2, d3, d4;
    logic         rm;
    int           lat;
    logic [128:0] q [$];
    logic [128:0] e;
    int           sent, got, cyc;
    bit           pending;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      b = ginv(8'(x));
      sb[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0};
    vecs[1] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1};
    vecs[2] = '{{16{8'h53}}, 1'b0, {16{8'hed}}, 1'b0};
    vecs[3] = '{{16{8'h00}}, 1'b0, {16{8'h63}}, 1'b0};
    vecs[4] = '{{16{8'h63}}, 1'b1, {16{8'h00}}, 1'b1};

    a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("reset_out_valid", a_out_valid, 0);
    chk("reset_out_data", a_out_data, 0);
    chk("reset_out_mode", a_out_mode, 0);
    chk("reset_in_ready", a_in_ready, 1);
    chk("reset_b_out_valid", b_out_valid, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_block(1'b0, vecs[i].din, vecs[i].mode, r, rm, lat);
      chk($sformatf("vec%0d_data", i), r, vecs[i].dexp);
      chk($sformatf("vec%0d_mode", i), rm, vecs[i].mexp);
      chk($sformatf("vec%0d_latency", i), lat, A_LAT);
    end

    // Forward-only instance: in_mode ignored, result and mode always forward.
    for (int i = 0; i < 5; i++) begin
      run_block(1'b1, vecs[i].din, vecs[i].mode, r, rm, lat);
      chk($sformatf("fwdonly%0d_data", i), r, ref_sub(vecs[i].din, 1'b0, 1'b0));
      chk($sformatf("fwdonly%0d_mode", i), rm, 0);
      chk($sformatf("fwdonly%0d_latency", i), lat, B_LAT);
    end

    // Backpressure: result held, no accept until release, then accept on the release edge.
    d1 = rnd128();
    a_in_valid = 1'b1; a_in_data = d1; a_in_mode = 1'b0; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, A_LAT);
    for (int c = 0; c < 10; c++) begin
      a_in_valid = c[0]; a_in_data = rnd128(); a_in_mode = 1'($urandom_range(1));
      @(posedge clk); #1;
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_data", a_out_data, ref_sub(d1, 1'b0, 1'b1));
      chk("bp_in_ready", a_in_ready, 0);
    end
    d2 = rnd128();
    a_in_valid = 1'b1; a_in_data = d2; a_in_mode = 1'b1; a_out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk("bp_consumed", a_out_valid, 0);
    lat = 0;
    while (!a_out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("bp_next_latency", lat, A_LAT);
    chk("bp_next_data", a_out_data, ref_sub(d2, 1'b1, 1'b1));
    chk("bp_next_mode", a_out_mode, 1);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;

    // Reset while the last beat is being issued.
    d3 = rnd128();
    a_in_valid = 1'b1; a_in_data = d3; a_in_mode = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #3 a_in_data = rnd128();
    chk("rst_mid_out_valid", a_out_valid, 0);
    chk("rst_mid_out_data", a_out_data, 0);
    chk("rst_mid_out_mode", a_out_mode, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_rel_in_ready", a_in_ready, 1);
    chk("rst_rel_out_valid", a_out_valid, 0);
    chk("rst_rel_out_data", a_out_data, 0);
    @(posedge clk); #1;
    d4 = rnd128();
    run_block(1'b0, d4, 1'b0, r, rm, lat);
    chk("rst_next_data", r, ref_sub(d4, 1'b0, 1'b1));
    chk("rst_next_mode", rm, 0);
    chk("rst_next_latency", lat, A_LAT);

    // Streaming: random blocks, modes and handshake duty against an in-order scoreboard.
    sent = 0; got = 0; cyc = 0; pending = 1'b0;
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra: got unexpected block %h expected none", a_out_data);
        end else begin
          e = q.pop_front();
          chk("stream_data", a_out_data, e[127:0]);
          chk("stream_mode", a_out_mode, e[128]);
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back({a_in_mode, ref_sub(a_in_data, a_in_mode, 1'b1)});
        sent++;
        pending = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (!pending) begin
        if (sent < 100 && $urandom_range(3) != 0) begin
          pending = 1'b1;
          a_in_valid = 1'b1; a_in_data = rnd128(); a_in_mode = 1'($urandom_range(1));
        end else begin
          a_in_valid = 1'b0; a_in_data = rnd128(); a_in_mode = 1'($urandom_range(1));
        end
      end
      a_out_ready = ($urandom_range(2) != 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk("stream_received", got, 100);
    chk("stream_sent", sent, 100);
    chk("stream_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
